nonce_ctrl: RTL
===============

NONCE_CTRL -- requirements
Module: nonce_ctrl

Interface
REQ-001 The block SHALL have parameter NONCE_W, default 32: nonce width in bits.
REQ-002 The block SHALL have parameter MAX_NONCE, default 2^NONCE_W-1: last nonce tried before exhaustion.
REQ-003 The block SHALL have parameter TIMEOUT, default 64: max cycles waited for a comparator verdict, range 1..255.
REQ-004 clk  input  1  clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  begin a search from nonce_base; sampled only in IDLE.
REQ-007 abort  input  1  terminate the current search.
REQ-008 nonce_base  input  NONCE_W  first nonce of the search.
REQ-009 valid  input  1  comparator verdict: hash meets target.
REQ-010 next  input  1  comparator verdict: hash fails, try next nonce.
REQ-011 nonce  output  NONCE_W  nonce presented to the hash stage.
REQ-012 hash_start  output  1  one-cycle pulse launching a hash of nonce.
REQ-013 busy  output  1  search in progress.
REQ-014 done  output  1  search ended; held until next start or reset.
REQ-015 found  output  1  search ended on valid; held with done.
REQ-016 exhausted  output  1  search ended with MAX_NONCE failing; held with done.
REQ-017 timeout_err  output  1  search ended on a verdict watchdog expiry; held with done.
REQ-018 golden_nonce  output  NONCE_W  nonce that produced valid.
REQ-019 attempts  output  NONCE_W  verdicts received in the current search.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, LAUNCH, WAIT and FINISH; all outputs SHALL be registered.
REQ-021 In IDLE, start=1 SHALL load nonce<=nonce_base, clear attempts, done, found, exhausted and timeout_err, set busy, and go to LAUNCH.
REQ-022 In LAUNCH, hash_start SHALL be 1 for exactly that cycle, the watchdog SHALL be cleared, and the next state SHALL be WAIT.
REQ-023 hash_start SHALL be 0 in every other state.
REQ-024 In WAIT, valid=1 SHALL set golden_nonce<=nonce, found<=1, done<=1, busy<=0, increment attempts, and go to FINISH.
REQ-025 In WAIT, valid=1 together with next=1 SHALL be treated as valid only.
REQ-026 In WAIT, next=1 with nonce!=MAX_NONCE SHALL increment nonce and attempts and go to LAUNCH; the new hash_start SHALL follow the verdict cycle by one cycle.
REQ-027 In WAIT, next=1 with nonce==MAX_NONCE SHALL increment attempts, set exhausted<=1, done<=1, busy<=0, and go to FINISH; nonce SHALL NOT wrap.
REQ-028 In WAIT, when neither verdict arrives for TIMEOUT consecutive cycles, the block SHALL set timeout_err<=1, done<=1, busy<=0 and go to FINISH.
REQ-029 attempts SHALL saturate at all-ones.
REQ-030 A verdict arriving in the same cycle as watchdog expiry SHALL take priority over the timeout.
REQ-031 abort=1 in LAUNCH or WAIT SHALL return the FSM to IDLE the next cycle with busy=0 and done=0; nonce and attempts SHALL hold their values.
REQ-032 abort SHALL be ignored in IDLE and FINISH.
REQ-033 abort SHALL take priority over a same-cycle verdict.
REQ-034 start SHALL be ignored outside IDLE and FINISH.
REQ-035 In FINISH, start=1 SHALL behave as in IDLE (REQ-021).
REQ-036 valid and next SHALL be ignored outside WAIT.

Reset
REQ-037 While reset=0 at a clock edge, the state SHALL become IDLE and nonce, golden_nonce, attempts, hash_start, busy, done, found, exhausted, timeout_err and the watchdog SHALL all become 0.
REQ-038 Reset SHALL override start, abort and verdicts, including when asserted mid-search.

Verification
REQ-039 Bench: nonce_base=5, start; answer next twice, then valid -> hash_start pulses for nonce 5, 6, 7; found=1, golden_nonce=7, attempts=3, done held.
REQ-040 Bench: NONCE_W=8, nonce_base=8'hFE; answer next for every launch -> launches at FE, FF; exhausted=1, attempts=2, nonce stays FF.
REQ-041 Bench: TIMEOUT=4; start, never answer -> timeout_err=1 exactly 4 cycles after entering WAIT; found=0.
REQ-042 Bench: in WAIT drive valid=1 and next=1 together -> found=1, no further hash_start; separately drive abort=1 with valid=1 -> IDLE, found=0, done=0.
REQ-043 Bench: pull reset=0 during WAIT with nonce=9 -> next cycle all outputs 0, state IDLE; a following start with nonce_base=0 launches nonce 0.
REQ-044 Bench: pulse start while busy -> ignored; pulse start in FINISH -> flags cleared and a new search launches.

Source files
------------

// File: rtl/nonce_ctrl.sv
// Nonce search sequencer: launches one hash per nonce, walks forward on "next" verdicts,
// and stops on a valid verdict, exhaustion at MAX_NONCE, abort, or a verdict watchdog expiry.
module nonce_ctrl #(
    parameter int                   NONCE_W   = 32,
    parameter logic [NONCE_W-1:0]   MAX_NONCE = {NONCE_W{1'b1}},
    parameter int                   TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_base,
    input  logic               valid,
    input  logic               next,
    output logic [NONCE_W-1:0] nonce,
    output logic               hash_start,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic [NONCE_W-1:0] attempts
);

    localparam int WD_W = 8;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] golden_q, golden_d;
    logic [NONCE_W-1:0] attempts_q, attempts_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               hash_start_q, hash_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic               timeout_err_q, timeout_err_d;

    logic               wd_expired;
    logic               at_max;
    logic               start_ok;
    logic [NONCE_W-1:0] attempts_inc;

    assign wd_expired   = (wd_q == WD_LAST);
    assign at_max       = (nonce_q == MAX_NONCE);
    assign start_ok     = start && ((state_q == IDLE) || (state_q == FINISH));
    assign attempts_inc = (&attempts_q) ? attempts_q : attempts_q + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort outranks verdicts, verdicts outrank the watchdog
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = LAUNCH;
            LAUNCH: state_d = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort)           state_d = IDLE;
                else if (valid)      state_d = FINISH;
                else if (next)       state_d = at_max ? FINISH : LAUNCH;
                else if (wd_expired) state_d = FINISH;
            end
            FINISH: if (start) state_d = LAUNCH;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        nonce_d       = nonce_q;
        golden_d      = golden_q;
        attempts_d    = attempts_q;
        wd_d          = wd_q;
        busy_d        = busy_q;
        done_d        = done_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        timeout_err_d = timeout_err_q;
        hash_start_d  = (state_d == LAUNCH);

        if (start_ok) begin
            nonce_d       = nonce_base;
            attempts_d    = '0;
            done_d        = 1'b0;
            found_d       = 1'b0;
            exhausted_d   = 1'b0;
            timeout_err_d = 1'b0;
            busy_d        = 1'b1;
        end

        unique case (state_q)
            LAUNCH: begin
                wd_d = '0;
                if (abort) begin
                    busy_d = 1'b0;
                    done_d = 1'b0;
                end
            end
            WAIT: begin
                if (abort) begin
                    busy_d = 1'b0;
                    done_d = 1'b0;
                end else if (valid) begin
                    golden_d   = nonce_q;
                    found_d    = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    attempts_d = attempts_inc;
                end else if (next) begin
                    attempts_d = attempts_inc;
                    if (at_max) begin
                        exhausted_d = 1'b1;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                    end else begin
                        nonce_d = nonce_q + 1'b1;
                    end
                end else if (wd_expired) begin
                    timeout_err_d = 1'b1;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            nonce_q       <= '0;
            golden_q      <= '0;
            attempts_q    <= '0;
            wd_q          <= '0;
            hash_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            nonce_q       <= nonce_d;
            golden_q      <= golden_d;
            attempts_q    <= attempts_d;
            wd_q          <= wd_d;
            hash_start_q  <= hash_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign nonce        = nonce_q;
    assign golden_nonce = golden_q;
    assign attempts     = attempts_q;
    assign hash_start   = hash_start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign timeout_err  = timeout_err_q;

endmodule
